// File: rtl/ms_tick_ctrl_if.sv
// ms_tick_ctrl_if
// Purpose : Bundles the control and status signals of the millisecond tick
//           controller so that the controller and its user connect through
//           one port.
// Ports   : start, stop, clear - level-sampled run / pause / reset-counts controls
//           div               - tick period minus one, in clk cycles
//           ms_tick           - one-cycle pulse per elapsed period
//           ms_count          - wrapping millisecond count
//           wrap              - pulses with the tick that wraps ms_count to 0
//           running           - high while the controller is in RUN
// Modports: master drives the controls and observes the status;
//           slave is the controller itself.
interface ms_tick_ctrl_if #(
    parameter int W     = 5,
    parameter int CNT_W = 10
);
    logic             start;
    logic             stop;
    logic             clear;
    logic [W-1:0]     div;
    logic             ms_tick;
    logic [CNT_W-1:0] ms_count;
    logic             wrap;
    logic             running;

    modport master (
        output start, stop, clear, div,
        input  ms_tick, ms_count, wrap, running
    );

    modport slave (
        input  start, stop, clear, div,
        output ms_tick, ms_count, wrap, running
    );
endinterface

// File: rtl/ms_tick_ctrl.sv
// ms_tick_ctrl
// Purpose : Runs a programmable prescaler, fires a one-cycle ms tick each
//           time the prescaler matches the latched divider, and accumulates
//           ticks in a count that wraps after MS_MAX.
// Ports   : clk    - clock, all state changes on the rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - ms_tick_ctrl_if slave modport (controls in, status out)
// Params  : W      - prescaler / divider width
//           CNT_W  - millisecond count width
//           MS_MAX - last count value before wrap (must be < 2**CNT_W)
module ms_tick_ctrl #(
    parameter int W      = 5,
    parameter int CNT_W  = 10,
    parameter int MS_MAX = 999
) (
    input  logic          clk,
    input  logic          rst_n,
    ms_tick_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MS_MAX_C = CNT_W'(MS_MAX);

    state_e           state_q, state_d;
    logic [W-1:0]     pre_q, pre_d;
    logic [W-1:0]     div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             match;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. CLEAR beats STOP beats START, so a START that
    // arrives together with STOP never leaves IDLE or PAUSE.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start && !bus.stop) state_d = RUN;
                RUN:     if (bus.stop)               state_d = PAUSE;
                PAUSE:   if (bus.start && !bus.stop) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: every status output comes straight from a flop.
    always_comb begin
        bus.running  = (state_q == RUN);
        bus.ms_tick  = tick_q;
        bus.wrap     = wrap_q;
        bus.ms_count = cnt_q;
    end

    assign match = (pre_q == div_q);

    // Datapath next values. A STOP on a match edge suppresses the match,
    // leaving PRE parked at DIV_Q so the first RUN edge after resume
    // produces the tick; this keeps RUN edges per tick at DIV_Q+1 across
    // pauses. The divider is relatched only at START-from-IDLE and on a match.
    always_comb begin
        pre_d  = pre_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.clear) begin
            pre_d = '0;
            div_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        div_d = bus.div;
                        pre_d = '0;
                    end
                end
                RUN: begin
                    if (!bus.stop) begin
                        if (match) begin
                            pre_d  = '0;
                            tick_d = 1'b1;
                            div_d  = bus.div;
                            if (cnt_q == MS_MAX_C) begin
                                cnt_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else begin
                            pre_d = pre_q + W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: doc/ms_tick_ctrl.md
# ms_tick_ctrl

Controller that sequences the 5-bit prescaler equality compare for the millisecond counter. It runs a programmable prescaler, fires a one-cycle millisecond tick on each prescaler match, and accumulates ticks in a wrapping millisecond count. It sits between the user start/stop/clear controls and the display/counter datapath.

## Interface
- W, 5, prescaler and divider width
- CNT_W, 10, millisecond count width
- MS_MAX, 999, last millisecond count value before wrap; must be < 2^CNT_W
- CLK  input  1  clock; all state changes on the rising edge
- RST_N  input  1  reset; one clock; reset is asynchronous and active-low
- START  input  1  level-sampled; run or resume
- STOP  input  1  level-sampled; pause
- CLEAR  input  1  level-sampled; return to IDLE and zero all counts
- DIV  input  W  tick period minus one, in CLK cycles
- MS_TICK  output  1  one-cycle pulse per elapsed period
- MS_COUNT  output  CNT_W  millisecond count
- WRAP  output  1  pulses with the MS_TICK that wraps MS_COUNT to 0
- RUNNING  output  1  high in RUN state

## Operation
- States: IDLE (reset state), RUN, PAUSE.
- Control priority at each edge: CLEAR > STOP > START.
- CLEAR in any state goes to IDLE. It forces PRE=0, MS_COUNT=0 and DIV_Q=0, and drops all pulses.
- IDLE + START goes to RUN. DIV_Q<=DIV and PRE<=0.
- RUN + STOP goes to PAUSE. This applies even if START is also high.
- PAUSE + START goes to RUN. DIV_Q is not relatched, and PRE resumes from its held value.
- Any other combination holds the current state.
- Internal prescaler PRE (W bits) runs only in RUN.
  - Each RUN edge with PRE != DIV_Q: PRE<=PRE+1.
  - Each RUN edge with PRE == DIV_Q (match): PRE<=0, MS_TICK<=1, DIV_Q<=DIV (relatch for the next period).
  - On a match, if MS_COUNT == MS_MAX: MS_COUNT<=0 and WRAP<=1. Otherwise MS_COUNT<=MS_COUNT+1.
- MS_TICK and WRAP are 0 on every edge without a match.
- DIV_Q=0 gives a tick on every RUN cycle.
- A DIV change takes effect only at START-from-IDLE or at a match.
- MS_COUNT arithmetic is unsigned CNT_W bits.
- MS_COUNT must never take values above MS_MAX.
- PRE never exceeds DIV_Q.

## Timing
- Reset values: RUNNING=0, MS_TICK=0, WRAP=0, MS_COUNT=0. Internally PRE=0, DIV_Q=0, state IDLE.
- All outputs are registered with no combinational input-to-output path.
- START accepted at edge e0: RUNNING=1 after e0.
- First MS_TICK is high during the cycle after edge e0+D+1, where D = DIV at e0.
- MS_COUNT updates on that same edge.
- Period between MS_TICK pulses is DIV_Q+1 cycles.
- STOP on the same edge as a match: STOP wins.
  - No tick and no increment occur, and PRE holds at DIV_Q.
  - The first RUN edge after resume produces the match.
- Pause is transparent to period accounting: total RUN edges per tick is exactly DIV_Q+1.
- CLEAR on the same edge as a match: no tick, no wrap, all counts zero.
- RST_N low mid-run: all outputs reach their reset values immediately (asynchronously).
- After RST_N deasserts, the block waits in IDLE for START.

## Test plan
- Reset and basic run:
  - Stimulus: reset, DIV=4, START pulse one cycle.
  - Required: MS_TICK every 5 cycles, first tick 5 edges after START edge, MS_COUNT 1,2,3… with each tick.
- DIV=0:
  - Stimulus: START with DIV=0.
  - Required: MS_TICK high every cycle, MS_COUNT increments every cycle.
- Wrap (MS_MAX=999, DIV=0):
  - Stimulus: run 1000 cycles.
  - Required: MS_COUNT 999→0 with WRAP=1 for exactly that cycle, and WRAP=0 otherwise.
- Pause on match edge:
  - Stimulus: DIV=3, assert STOP on the match edge, hold 10 cycles, then START.
  - Required: no tick while paused, RUNNING=0, tick on first resumed edge, MS_COUNT unchanged through pause.
- Priority and DIV relatch:
  - Stimulus 1: START+STOP+CLEAR together while in RUN. Required: IDLE, all zero.
  - Stimulus 2: START+STOP together in RUN. Required: PAUSE.
  - Stimulus 3: change DIV 4→2 mid-period. Required: the current period stays 5 cycles, the following periods are 3 cycles.
- Async reset mid-run:
  - Stimulus: drop RST_N between clock edges with MS_COUNT=37.
  - Required: outputs reset before the next edge.
  - Required: after release and START with DIV=1, ticks every 2 cycles starting from MS_COUNT=1.
